alu_issue_ctrl: RTL and testbench

Sequential front end for the parameterised ALU: accepts operation requests over a valid/ready handshake, registers and drives them onto the ALU's operand/control inputs, captures the ALU result and flags one settle cycle later, and holds them on a valid/ready response port until consumed. It sits between a requester (sequencer, bench or future datapath controller) and the combinational ALU. It is the initiator side of the ALU interface. It rejects opcodes outside the implemented set and keeps operation counters.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 102 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU issue front end.
package alu_pkg;

  typedef enum logic [3:0] {
    AND = 4'd0,
    OR  = 4'd1,
    ADD = 4'd2,
    INC = 4'd3,
    DEC = 4'd4,
    NOT = 4'd5,
    SUB = 4'd6,
    XOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issue_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for the combinational ALU: registers requests onto the
// ALU inputs, captures the result one cycle later and holds it until consumed.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [3:0]       req_op,
  input  logic [1:0]       req_flag_in,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_control,
  output logic [1:0]       alu_flag_in,
  input  logic [N-1:0]     alu_result,
  input  logic [1:0]       alu_flags,
  input  logic [1:0]       alu_c_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [1:0]       rsp_flags,
  output logic [1:0]       rsp_c_flag,
  output logic [3:0]       rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  issue_state_e state;

  // req_ready/rsp_valid are registered alongside state so both are pure state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      alu_flag_in <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_c_flag  <= '0;
      rsp_op      <= '0;
      rsp_err     <= 1'b0;
      done_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_op    <= req_op;
            req_ready <= 1'b0;
            if (op_legal(req_op)) begin
              alu_a       <= req_a;
              alu_b       <= req_b;
              alu_control <= req_op;
              alu_flag_in <= req_flag_in;
              state       <= ISSUE;
            end else begin
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_c_flag <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_c_flag <= alu_c_flag;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
            if (rsp_err) err_cnt  <= err_cnt + CNT_W'(1);
            else         done_cnt <= done_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised and directed bench for alu_issue_ctrl with a stand-in ALU and a
// transaction-level reference model.
module tb_alu_issue_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [N-1:0]     req_a = '0;
  logic [N-1:0]     req_b = '0;
  logic [3:0]       req_op = '0;
  logic [1:0]       req_flag_in = '0;
  logic [N-1:0]     alu_a, alu_b;
  logic [3:0]       alu_control;
  logic [1:0]       alu_flag_in;
  logic [N-1:0]     alu_result;
  logic [1:0]       alu_flags, alu_c_flag;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [N-1:0]     rsp_result;
  logic [1:0]       rsp_flags, rsp_c_flag;
  logic [3:0]       rsp_op;
  logic             rsp_err;
  logic [CNT_W-1:0] done_cnt, err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  int exp_done = 0;
  int exp_err  = 0;
  logic [N-1:0] exp_alu_a = '0, exp_alu_b = '0;
  logic [3:0]   exp_alu_ctl = '0;
  logic [1:0]   exp_alu_fin = '0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_flag_in(req_flag_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_flag_in(alu_flag_in),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_c_flag(alu_c_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_c_flag(rsp_c_flag),
    .rsp_op(rsp_op), .rsp_err(rsp_err),
    .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  // Stand-in ALU: returns {c_flag, flags, result}.
  function automatic logic [N+3:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [3:0] op, input logic [1:0] fin);
    int w;
    logic [N-1:0] r;
    case (op)
      4'd0: w = a & b;
      4'd1: w = a | b;
      4'd2: w = int'(a) + int'(b) + int'(fin[0]);
      4'd3: w = int'(a) + 1;
      4'd4: w = int'(a) - 1;
      4'd5: w = int'(~a);
      4'd6: w = int'(a) - int'(b) - int'(fin[0]);
      4'd7: w = a ^ b;
      4'd8: w = int'(a) << b;
      4'd9: w = int'(a) >> b;
      default: w = 0;
    endcase
    r = w[N-1:0];
    return {w[N], fin[1], (r == '0), r[N-1], r};
  endfunction

  assign {alu_c_flag, alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_control, alu_flag_in);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rsp(input string pfx, input logic [N+3:0] e, input logic [3:0] op, input logic err);
    check_eq({pfx, " rsp_valid"}, rsp_valid, 1);
    check_eq({pfx, " req_ready"}, req_ready, 0);
    check_eq({pfx, " rsp_result"}, rsp_result, e[N-1:0]);
    check_eq({pfx, " rsp_flags"}, rsp_flags, e[N+1:N]);
    check_eq({pfx, " rsp_c_flag"}, rsp_c_flag, e[N+3:N+2]);
    check_eq({pfx, " rsp_op"}, rsp_op, op);
    check_eq({pfx, " rsp_err"}, rsp_err, err);
    check_eq({pfx, " alu_a"}, alu_a, exp_alu_a);
    check_eq({pfx, " alu_b"}, alu_b, exp_alu_b);
    check_eq({pfx, " alu_control"}, alu_control, exp_alu_ctl);
    check_eq({pfx, " alu_flag_in"}, alu_flag_in, exp_alu_fin);
  endtask

  // One complete transaction; rsp_ready held low for 'hold' cycles once the response is up.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                        input logic [1:0] fin, input int hold);
    logic legal;
    logic [N+3:0] e;
    legal = (op < 10);
    e = legal ? alu_model(a, b, op, fin) : '0;
    @(negedge clk);
    check_eq("idle req_ready", req_ready, 1);
    check_eq("idle rsp_valid", rsp_valid, 0);
    req_a = a; req_b = b; req_op = op; req_flag_in = fin; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = N'($urandom); req_b = N'($urandom); req_op = 4'($urandom);
    if (legal) begin
      exp_alu_a = a; exp_alu_b = b; exp_alu_ctl = op; exp_alu_fin = fin;
      check_eq("issue alu_control", alu_control, op);
      check_eq("issue alu_a", alu_a, a);
      check_eq("issue rsp_valid", rsp_valid, 0);
      check_eq("issue req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    check_rsp("resp", e, op, !legal);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_a = N'($urandom); req_b = N'($urandom);
      req_op = 4'($urandom); req_flag_in = 2'($urandom);
      @(posedge clk); #1;
      check_rsp("hold", e, op, !legal);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (legal) exp_done = (exp_done + 1) % (1 << CNT_W);
    else       exp_err  = (exp_err + 1) % (1 << CNT_W);
    check_eq("done rsp_valid", rsp_valid, 0);
    check_eq("done req_ready", req_ready, 1);
    check_eq("done_cnt", done_cnt, exp_done);
    check_eq("err_cnt", err_cnt, exp_err);
    check_eq("kept rsp_result", rsp_result, e[N-1:0]);
    check_eq("kept rsp_op", rsp_op, op);
    rsp_ready = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, " req_ready"}, req_ready, 1);
    check_eq({pfx, " rsp_valid"}, rsp_valid, 0);
    check_eq({pfx, " alu_a"}, alu_a, 0);
    check_eq({pfx, " alu_b"}, alu_b, 0);
    check_eq({pfx, " alu_control"}, alu_control, 0);
    check_eq({pfx, " alu_flag_in"}, alu_flag_in, 0);
    check_eq({pfx, " rsp_result"}, rsp_result, 0);
    check_eq({pfx, " rsp_flags"}, rsp_flags, 0);
    check_eq({pfx, " rsp_c_flag"}, rsp_c_flag, 0);
    check_eq({pfx, " rsp_op"}, rsp_op, 0);
    check_eq({pfx, " rsp_err"}, rsp_err, 0);
    check_eq({pfx, " done_cnt"}, done_cnt, 0);
    check_eq({pfx, " err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 7+9 with carry-in: 17 -> result 1, carry out
    run_op(4'h7, 4'h9, 4'd2, 2'd1, 0);
    run_op(4'h3, 4'h0, 4'd5, 2'd0, 0);
    run_op(4'h3, 4'h2, 4'd8, 2'd0, 0);
    run_op(4'h5, 4'h6, 4'hC, 2'd3, 0);
    run_op(4'hA, 4'h5, 4'd6, 2'd2, 5);
    run_op(4'h1, 4'h1, 4'hF, 2'd0, 5);

    // reset while the ALU operands are being issued
    @(negedge clk);
    req_a = 4'h9; req_b = 4'h4; req_op = 4'd7; req_flag_in = 2'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("pre-reset alu_control", alu_control, 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 0; exp_err = 0;
    exp_alu_a = '0; exp_alu_b = '0; exp_alu_ctl = '0; exp_alu_fin = '0;
    @(posedge clk); #1;
    check_reset_outputs("post reset");

    for (int i = 0; i < 256; i++)
      run_op(N'($urandom), N'($urandom), 4'($urandom_range(0, 9)), 2'($urandom), 0);
    check_eq("wrap done_cnt", done_cnt, 0);
    check_eq("wrap err_cnt", err_cnt, 0);

    for (int i = 0; i < 80; i++)
      run_op(N'($urandom), N'($urandom), 4'($urandom_range(0, 15)), 2'($urandom),
             int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
